// File: rtl/ssd1306_text_console_if.sv
// Character byte stream into the SSD1306 text console.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
// the source holds in_data stable while in_valid is high and in_ready is low.
interface ssd1306_text_console_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ssd1306_text_console.sv
// 16x4 text console: turns a byte stream into text RAM cell writes with cursor,
// control codes, clear and (with TEXT_CONSOLE_SCROLL_EN defined) scroll-up.
module ssd1306_text_console #(
  parameter int TEXT_WIDTH  = 16,
  parameter int TEXT_HEIGHT = 4,
  parameter int TEXT_SZ     = $clog2(TEXT_WIDTH*TEXT_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  ssd1306_text_console_if.slave s_in,
  input  logic                  clear,
  output logic                  busy,
  output logic [3:0]            cursor_col,
  output logic [1:0]            cursor_row,
  output logic                  text_wr_ena,
  output logic [7:0]            text_wr_data,
  output logic [TEXT_SZ-1:0]    text_wr_addr,
  output logic [1:0]            dbg_state
);

  localparam int         CELLS    = TEXT_WIDTH * TEXT_HEIGHT;
  localparam int         LAST_COL = TEXT_WIDTH - 1;
  localparam int         LAST_ROW = TEXT_HEIGHT - 1;
  localparam int         CW       = TEXT_SZ + 1;
  localparam logic [7:0] BLANK    = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SCROLL = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_col;
  logic [1:0]         r_row;
  logic               r_wr_ena;
  logic [7:0]         r_wr_data;
  logic [TEXT_SZ-1:0] r_wr_addr;

  logic w_accept;
  logic w_printable;
  logic w_last_col;
  logic w_last_row;

  assign w_accept    = s_in.in_valid && s_in.in_ready;
  assign w_printable = (s_in.in_data >= 8'h20) && (s_in.in_data <= 8'h7E);
  assign w_last_col  = (r_col == 4'(LAST_COL));
  assign w_last_row  = (r_row == 2'(LAST_ROW));

`ifdef TEXT_CONSOLE_SCROLL_EN
  logic [7:0]         r_shadow [CELLS];
  logic [TEXT_SZ-1:0] w_src_idx;
  logic [7:0]         w_src_data;
  logic [7:0]         w_scroll_data;

  always_ff @(posedge clk) begin
    if (r_wr_ena) r_shadow[r_wr_addr] <= r_wr_data;
  end

  // Source cell is one row below the target; the in-flight write is bypassed
  // because the shadow only commits it on the following edge.
  assign w_src_idx  = (r_state == S_SCROLL) ? r_cnt[TEXT_SZ-1:0] + TEXT_SZ'(TEXT_WIDTH)
                                            : TEXT_SZ'(TEXT_WIDTH);
  assign w_src_data = (r_wr_ena && (r_wr_addr == w_src_idx)) ? r_wr_data : r_shadow[w_src_idx];
  assign w_scroll_data = ((r_state == S_SCROLL) &&
                          (r_cnt[TEXT_SZ-1:0] >= TEXT_SZ'(CELLS - TEXT_WIDTH))) ? BLANK : w_src_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_wr_ena  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= BLANK;
    end else if (clear) begin
      // Clear always wins: restart the blanking pass with cell 0 written now.
      r_state   <= S_CLEAR;
      r_cnt     <= CW'(1);
      r_wr_ena  <= 1'b1;
      r_wr_addr <= '0;
      r_wr_data <= BLANK;
    end else begin
      r_wr_ena <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              r_wr_ena  <= 1'b1;
              r_wr_addr <= TEXT_SZ'({r_row, r_col});
              r_wr_data <= s_in.in_data;
              if (!w_last_col) begin
                r_col <= r_col + 4'd1;
              end else begin
                r_col <= '0;
                if (!w_last_row) begin
                  r_row <= r_row + 2'd1;
                end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                  r_state <= S_SCROLL;
                  r_cnt   <= '0;
`else
                  r_row <= '0;
`endif
                end
              end
            end else begin
              case (s_in.in_data)
                8'h0A: begin
                  r_col <= '0;
                  if (!w_last_row) begin
                    r_row <= r_row + 2'd1;
                  end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                    // Output register is free here, so cell 0 goes out immediately.
                    r_state   <= S_SCROLL;
                    r_cnt     <= CW'(1);
                    r_wr_ena  <= 1'b1;
                    r_wr_addr <= '0;
                    r_wr_data <= w_scroll_data;
`else
                    r_row <= '0;
`endif
                  end
                end
                8'h0D: r_col <= '0;
                8'h08: begin
                  if (r_col != 4'd0) r_col <= r_col - 4'd1;
                end
                8'h0C: begin
                  r_state   <= S_CLEAR;
                  r_cnt     <= CW'(1);
                  r_wr_ena  <= 1'b1;
                  r_wr_addr <= '0;
                  r_wr_data <= BLANK;
                end
                default: ;
              endcase
            end
          end
        end
        S_CLEAR: begin
          if (r_cnt[TEXT_SZ]) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
          end else begin
            r_wr_ena  <= 1'b1;
            r_wr_addr <= r_cnt[TEXT_SZ-1:0];
            r_wr_data <= BLANK;
            r_cnt     <= r_cnt + CW'(1);
          end
        end
`ifdef TEXT_CONSOLE_SCROLL_EN
        S_SCROLL: begin
          if (r_cnt[TEXT_SZ]) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= 2'(LAST_ROW);
          end else begin
            r_wr_ena  <= 1'b1;
            r_wr_addr <= r_cnt[TEXT_SZ-1:0];
            r_wr_data <= w_scroll_data;
            r_cnt     <= r_cnt + CW'(1);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_in.in_ready = (r_state == S_IDLE) && !clear;
  assign busy          = (r_state != S_IDLE);
  assign cursor_col    = r_col;
  assign cursor_row    = r_row;
  assign text_wr_ena   = r_wr_ena;
  assign text_wr_data  = r_wr_data;
  assign text_wr_addr  = r_wr_addr;
  assign dbg_state     = r_state;

endmodule

// File: doc/ssd1306_text_console.md
SSD1306_TEXT_CONSOLE -- requirements
Module: ssd1306_text_console

Interface
REQ-001 Parameter TEXT_WIDTH, default 16, number of character columns; the block supports the 16x4 display only.
REQ-002 Parameter TEXT_HEIGHT, default 4, number of character rows.
REQ-003 Parameter TEXT_SZ, default $clog2(TEXT_WIDTH*TEXT_HEIGHT)=6, text address width.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; drives all state and the text RAM write port.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  a character byte is offered.
REQ-008 in_data  input  8  character byte; ASCII and control codes.
REQ-009 in_ready  output  1  a byte is accepted on a cycle with in_valid&&in_ready.
REQ-010 clear  input  1  single-cycle request to blank the screen and home the cursor.
REQ-011 busy  output  1  high whenever the block is not in S_IDLE.
REQ-012 cursor_col  output  4  current cursor column, 0-15.
REQ-013 cursor_row  output  2  current cursor row, 0-3.
REQ-014 text_wr_ena  output  1  text RAM write strobe, one cell per cycle.
REQ-015 text_wr_data  output  8  character code to write.
REQ-016 text_wr_addr  output  TEXT_SZ  cell address = row*16+col.

Function
REQ-017 States SHALL be S_IDLE, S_CLEAR and S_SCROLL; in_ready SHALL equal (state==S_IDLE && !clear).
REQ-018 The block SHALL keep a 64-byte shadow copy of the screen, updated on every text RAM write.
REQ-019 Printable byte 0x20-0x7E accepted at cursor (r,c): the next cycle SHALL drive text_wr_ena=1, addr=r*16+c, data=byte; the cursor then advances one column.
REQ-020 Advancing past col 15 SHALL move the cursor to col 0 of row r+1.
REQ-021 0x0A (LF) SHALL move the cursor to col 0, row r+1, with no write.
REQ-022 0x0D (CR) SHALL move the cursor to col 0, with no write.
REQ-023 0x08 (BS) SHALL decrement col if col>0; at col 0 the byte is a no-op.
REQ-024 0x0C (FF) SHALL behave as clear.
REQ-025 All other bytes SHALL be consumed with no write and no cursor change.
REQ-026 A cursor move to row 4 SHALL enter S_SCROLL.
REQ-027 S_SCROLL SHALL run 64 write cycles, addr 0..63 ascending: data=shadow[addr+16] for addr<48, else 0x20; on exit the cursor is (3,0) and the state returns to S_IDLE.
REQ-028 S_CLEAR SHALL run 64 write cycles, addr 0..63, data=0x20; on exit the cursor is (0,0) and the state returns to S_IDLE.
REQ-029 clear asserted in any state SHALL abort the current sequence and restart S_CLEAR at addr 0 on the next cycle.
REQ-030 When clear and in_valid are asserted in the same cycle, clear SHALL win and the byte SHALL not be accepted.
REQ-031 text_wr_ena SHALL be 0 in S_IDLE except on the cycle following a printable accept.

Reset
REQ-032 On reset assertion: text_wr_ena=0, text_wr_addr=0, text_wr_data=0x20, cursor=(0,0), busy=1, in_ready=0.
REQ-033 After reset release the block SHALL enter S_CLEAR (64 cycles) before first asserting in_ready.
REQ-034 Reset asserted mid-sequence SHALL abandon the sequence, and the block SHALL restart with S_CLEAR after release.

Configuration
REQ-035 With TEXT_CONSOLE_SCROLL_EN defined, a move to row 4 SHALL scroll as specified in REQ-027.
REQ-036 Without TEXT_CONSOLE_SCROLL_EN, a move to row 4 SHALL wrap the cursor to (0,0) with no RAM writes; S_SCROLL logic and the shadow buffer SHALL be omitted.

Verification
REQ-037 Release reset, wait, then drive 'A' (0x41) -> 64 writes of 0x20, then a write addr=0 data=0x41, cursor=(0,1).
REQ-038 Send 17 'x' bytes -> the 17th write has addr=16, and the cursor ends at (1,1).
REQ-039 Cursor at (3,5); send LF (SCROLL_EN) -> busy for 64 cycles; writes at addr 0-47 replicate the old rows 1-3; addr 48-63 = 0x20; cursor=(3,0).
REQ-040 Same stimulus without SCROLL_EN -> no writes, cursor=(0,0).
REQ-041 Assert clear together with in_valid=0x41 mid-scroll -> 0x41 not accepted; the clear restarts at addr 0 and completes 64 writes of 0x20; cursor=(0,0).
REQ-042 Send BS at (2,0), then 0x07 -> no writes; cursor stays (2,0); in_ready stays high.
